// File: rtl/byte_stream_packer_pkg.sv
// Shared definitions for the byte stream packer: width helpers, default widths
// and the flush FSM state encoding.
package byte_stream_packer_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 64;

  function automatic int myclog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/byte_shift_insert.sv
// Combinational next-state for the packer byte buffer: an optional fixed
// down-shift by one output word merged with a count-indexed byte append.
module byte_shift_insert
  import byte_stream_packer_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int OUT_BYTES = 8,
  parameter int CNT_W     = 4,
  parameter int N_W       = 3
) (
  input  logic [(OUT_BYTES+IN_BYTES)*8-1:0] buf_cur,
  input  logic [CNT_W-1:0]                  cnt,
  input  logic                              pop,
  input  logic                              push,
  input  logic [IN_BYTES*8-1:0]             in_data,
  input  logic [N_W-1:0]                    nbytes,
  output logic [(OUT_BYTES+IN_BYTES)*8-1:0] buf_next,
  output logic [CNT_W-1:0]                  cnt_next
);

  localparam int BUF_BYTES = OUT_BYTES + IN_BYTES;

  int c;
  int popped;
  int taken;
  int base;
  logic [BUF_BYTES*8-1:0] src;

  // Pushed bytes land right after whatever survives the pop this cycle.
  always_comb begin
    c        = int'(cnt);
    popped   = pop ? ((c > OUT_BYTES) ? OUT_BYTES : c) : 0;
    taken    = push ? int'(nbytes) : 0;
    base     = c - popped;
    src      = (popped != 0) ? (buf_cur >> (OUT_BYTES * 8)) : buf_cur;
    buf_next = src;
    for (int i = 0; i < BUF_BYTES; i++) begin
      if (i >= base && i < base + taken) begin
        buf_next[i*8 +: 8] = in_data[(i-base)*8 +: 8];
      end
    end
    cnt_next = CNT_W'(base + taken);
  end

endmodule

// File: rtl/byte_stream_packer.sv
// Packs variable-length byte beats into full little-endian output words and
// drains any residue as a single padded word on flush.
module byte_stream_packer
  import byte_stream_packer_pkg::*;
#(
  parameter int         IN_W     = DEF_IN_W,
  parameter int         OUT_W    = DEF_OUT_W,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic [IN_W-1:0]                          in_data,
  input  logic [myclog2(bytes_of(IN_W)+1)-1:0]     in_nbytes,
  output logic                                     in_ready,
  input  logic                                     flush,
  output logic                                     flush_done,
  output logic                                     w_req,
  output logic [OUT_W-1:0]                         data_o,
  input  logic                                     full,
  output logic [myclog2(bytes_of(OUT_W)+1)-1:0]    out_nbytes,
  output logic                                     busy
);

  localparam int IN_BYTES  = bytes_of(IN_W);
  localparam int OUT_BYTES = bytes_of(OUT_W);
  localparam int BUF_BYTES = OUT_BYTES + IN_BYTES;
  localparam int CNT_W     = myclog2(BUF_BYTES + 1);
  localparam int N_W       = myclog2(IN_BYTES + 1);
  localparam int ON_W      = myclog2(OUT_BYTES + 1);

  logic [BUF_BYTES*8-1:0] byte_buf;
  logic [BUF_BYTES*8-1:0] buf_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  state_t                 state;
  logic                   alive;
  logic                   push;
  logic                   pop;
  logic [N_W-1:0]         n_clamped;

  // alive keeps in_ready low while reset is held, even though cnt and state
  // already look idle.
  assign in_ready   = alive && (state == ST_RUN) && (cnt <= CNT_W'(OUT_BYTES));
  assign w_req      = (cnt >= CNT_W'(OUT_BYTES)) || ((state == ST_FLUSH) && (cnt != '0));
  assign push       = in_valid && in_ready;
  assign pop        = w_req && !full;
  assign n_clamped  = (in_nbytes > N_W'(IN_BYTES)) ? N_W'(IN_BYTES) : in_nbytes;
  assign out_nbytes = (cnt >= CNT_W'(OUT_BYTES)) ? ON_W'(OUT_BYTES) : ON_W'(cnt);
  assign flush_done = (state == ST_FLUSH) && (cnt_next == '0);
  assign busy       = (cnt != '0) || (state != ST_RUN);

  always_comb begin
    data_o = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      data_o[j*8 +: 8] = (CNT_W'(j) < cnt) ? byte_buf[j*8 +: 8] : PAD_BYTE;
    end
  end

  byte_shift_insert #(
    .IN_BYTES (IN_BYTES),
    .OUT_BYTES(OUT_BYTES),
    .CNT_W    (CNT_W),
    .N_W      (N_W)
  ) u_shift (
    .buf_cur (byte_buf),
    .cnt     (cnt),
    .pop     (pop),
    .push    (push),
    .in_data (in_data),
    .nbytes  (n_clamped),
    .buf_next(buf_next),
    .cnt_next(cnt_next)
  );

  // A push in the same cycle as flush is already folded into cnt_next, so
  // it is drained along with the rest of the residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_buf <= '0;
      cnt      <= '0;
      state    <= ST_RUN;
      alive    <= 1'b0;
    end else begin
      alive    <= 1'b1;
      byte_buf <= buf_next;
      cnt      <= cnt_next;
      case (state)
        ST_RUN:   if (flush) state <= ST_FLUSH;
        ST_FLUSH: if (cnt_next == '0) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule
